// File: rtl/eth_mdio_pkg.sv
// =============================================================================
// Module   : eth_mdio_pkg
// Brief    : Clause-22 MDIO frame constants, state encoding and field decode.
//            ETH_MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package eth_mdio_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PRE   = 4'd1,
        ST    = 4'd2,
        OP    = 4'd3,
        PHYAD = 4'd4,
        REGAD = 4'd5,
        TA    = 4'd6,
        DATA  = 4'd7,
        DONE  = 4'd8
    } mdio_state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam int         PRE_BITS = 32;

`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    localparam int PRE_LEN = 0;
`else
    localparam int PRE_LEN = PRE_BITS;
`endif

    localparam int NBITS    = PRE_LEN + 32;
    localparam int PRE_SKIP = PRE_BITS - PRE_LEN;

    // Position 47 of a full-length frame is the second turnaround bit.
    localparam logic [6:0] TA2_POS = 7'd47;

    function automatic mdio_state_t field_state(input logic [6:0] bit_idx);
        logic [6:0]  pos;
        mdio_state_t st;
        pos = bit_idx + 7'(PRE_SKIP);
        if (pos < 7'd32)      st = PRE;
        else if (pos < 7'd34) st = ST;
        else if (pos < 7'd36) st = OP;
        else if (pos < 7'd41) st = PHYAD;
        else if (pos < 7'd46) st = REGAD;
        else if (pos < 7'd48) st = TA;
        else                  st = DATA;
        return st;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_mdio_clkgen.sv
// =============================================================================
// Module   : eth_mdio_clkgen
// Brief    : MDC generator: CLK_DIV cycles low then CLK_DIV high per bit, with
//            strobes on the last cycle of each half.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module eth_mdio_clkgen #(
    parameter int CLK_DIV = 50
) (
    input  logic msoc_clk,
    input  logic rst_int_n,
    input  logic i_run,
    output logic o_mdc,
    output logic o_fall_stb,
    output logic o_sample_stb
);

    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_mdc;
    logic             w_half_end;

    always_ff @(posedge msoc_clk) begin
        if (!rst_int_n || !i_run) begin
            r_div <= '0;
            r_mdc <= 1'b0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            r_mdc <= ~r_mdc;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_half_end   = i_run & (r_div == c_div_last);
    assign o_mdc        = r_mdc;
    assign o_fall_stb   = w_half_end & r_mdc;
    assign o_sample_stb = w_half_end & ~r_mdc;

endmodule

`default_nettype wire

// File: rtl/eth_mdio_master.sv
// =============================================================================
// Module   : eth_mdio_master
// Brief    : Clause-22 MDIO management master, one request/response per frame.
//            Define ETH_MDIO_PREAMBLE_SUPPRESS_EN to omit the preamble.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module eth_mdio_master
    import eth_mdio_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic        msoc_clk,
    input  logic        rst_int_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        phy_mdc,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oen,
    input  logic        phy_mdio_i
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("eth_mdio_master: CLK_DIV must be at least 2");
    end

    mdio_state_t      r_state;
    logic [6:0]       r_bit_cnt;
    logic [NBITS-1:0] r_tx;
    logic [15:0]      r_rx;
    logic             r_write;
    logic             r_ta_err;
    logic             r_mdio_o;
    logic             r_mdio_oen;
    logic             r_rsp_valid;
    logic [15:0]      r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_run;
    logic             w_fall;
    logic             w_sample;
    logic             w_mdc;
    logic [31:0]      w_body;
    logic [NBITS-1:0] w_frame;
    logic [6:0]       w_pos;
    mdio_state_t      w_next_field;

    assign w_run = (r_state != IDLE) && (r_state != DONE);

    eth_mdio_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .msoc_clk     (msoc_clk),
        .rst_int_n    (rst_int_n),
        .i_run        (w_run),
        .o_mdc        (w_mdc),
        .o_fall_stb   (w_fall),
        .o_sample_stb (w_sample)
    );

    // Read TA/DATA bits are ones so the released line idles high.
    assign w_body = {ST_CODE,
                     req_write ? OP_WRITE : OP_READ,
                     req_phy_addr,
                     req_reg_addr,
                     req_write ? 2'b10 : 2'b11,
                     req_write ? req_wdata : 16'hFFFF};

`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    assign w_frame = w_body;
`else
    assign w_frame = {{PRE_BITS{1'b1}}, w_body};
`endif

    assign w_pos        = r_bit_cnt + 7'(PRE_SKIP);
    assign w_next_field = field_state(r_bit_cnt + 7'd1);

    always_ff @(posedge msoc_clk) begin
        if (!rst_int_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_write     <= 1'b0;
            r_ta_err    <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oen  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state    <= field_state(7'd0);
                        r_bit_cnt  <= '0;
                        r_tx       <= w_frame;
                        r_write    <= req_write;
                        r_rx       <= '0;
                        r_ta_err   <= 1'b0;
                        r_mdio_o   <= w_frame[NBITS-1];
                        r_mdio_oen <= 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
                    r_rsp_err   <= ~r_write & r_ta_err;
                end
                default: begin
                    if (w_sample) begin
                        if (r_state == TA && w_pos == TA2_POS && phy_mdio_i)
                            r_ta_err <= 1'b1;
                        if (r_state == DATA)
                            r_rx <= {r_rx[14:0], phy_mdio_i};
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == 7'(NBITS - 1)) begin
                            r_state    <= DONE;
                            r_mdio_o   <= 1'b1;
                            r_mdio_oen <= 1'b0;
                        end else begin
                            r_state    <= w_next_field;
                            r_bit_cnt  <= r_bit_cnt + 7'd1;
                            r_tx       <= {r_tx[NBITS-2:0], 1'b0};
                            r_mdio_o   <= r_tx[NBITS-2];
                            r_mdio_oen <= r_write | ~((w_next_field == TA) || (w_next_field == DATA));
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign busy         = ~req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign phy_mdc      = w_mdc;
    assign phy_mdio_o   = r_mdio_o;
    assign phy_mdio_oen = r_mdio_oen;

endmodule

`default_nettype wire

// File: tb/tb_eth_mdio_master.sv
// =============================================================================
// Module   : tb_eth_mdio_master
// Brief    : Directed self-checking bench for eth_mdio_master (CLK_DIV=4).
//            Honours ETH_MDIO_PREAMBLE_SUPPRESS_EN for the expected frame length.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_eth_mdio_master;

    localparam int CLK_DIV = 4;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    localparam int NB = 32;
`else
    localparam int NB = 64;
`endif
    localparam int FRAME_CYC = 2 * CLK_DIV * NB;

    logic        msoc_clk = 1'b0;
    logic        rst_int_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_phy_addr;
    logic [4:0]  req_reg_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        phy_mdc;
    logic        phy_mdio_o;
    logic        phy_mdio_oen;
    logic        phy_mdio_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 msoc_clk = ~msoc_clk;

    eth_mdio_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .msoc_clk     (msoc_clk),
        .rst_int_n    (rst_int_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_phy_addr (req_phy_addr),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .phy_mdc      (phy_mdc),
        .phy_mdio_o   (phy_mdio_o),
        .phy_mdio_oen (phy_mdio_oen),
        .phy_mdio_i   (phy_mdio_i)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge msoc_clk);
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check_val({tag, "_mdc"}, 64'(phy_mdc), 64'd0);
        check_val({tag, "_oen"}, 64'(phy_mdio_oen), 64'd0);
        check_val({tag, "_o"}, 64'(phy_mdio_o), 64'd1);
    endtask

    // Presents a request, follows the whole frame and ends in the response cycle.
    // body is the hand-computed 32-bit frame after the preamble, as seen on phy_mdio_o.
    task automatic run_frame(input string tag, input logic wr, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd, input logic hold,
                             input logic [31:0] body, input logic [17:0] phy_bits,
                             input logic [15:0] exp_rd, input logic exp_err);
        logic [63:0] exp_o, exp_oen, obs_o, obs_oen, mask;
        int mdc_bad, busy_bad, b, half;
        mask     = (NB == 64) ? {64{1'b1}} : {32'h0, {32{1'b1}}};
        exp_o    = (NB == 64) ? {32'hFFFF_FFFF, body} : {32'h0, body};
        exp_oen  = wr ? mask : (mask & ~64'h3FFFF);
        obs_o    = '0;
        obs_oen  = '0;
        mdc_bad  = 0;
        busy_bad = 0;

        req_write    = wr;
        req_phy_addr = pa;
        req_reg_addr = ra;
        req_wdata    = wd;
        req_valid    = 1'b1;
        step();
        if (!hold) begin
            req_valid    = 1'b0;
            req_write    = ~wr;
            req_phy_addr = ~pa;
            req_reg_addr = ~ra;
            req_wdata    = ~wd;
        end

        for (int c = 0; c < FRAME_CYC; c++) begin
            b    = c / (2 * CLK_DIV);
            half = c % (2 * CLK_DIV);
            if (half == 0) begin
                obs_o   = {obs_o[62:0], phy_mdio_o};
                obs_oen = {obs_oen[62:0], phy_mdio_oen};
                phy_mdio_i = (!wr && b >= NB - 18) ? phy_bits[NB - 1 - b] : 1'b1;
            end
            if (phy_mdc !== (half >= CLK_DIV)) mdc_bad++;
            if (busy !== 1'b1) busy_bad++;
            step();
        end
        phy_mdio_i = 1'b1;

        check_val({tag, "_mdio_bits"}, obs_o, exp_o);
        check_val({tag, "_oen_bits"}, obs_oen, exp_oen);
        check_val({tag, "_mdc_timing_errs"}, 64'(mdc_bad), 64'd0);
        check_val({tag, "_busy_errs"}, 64'(busy_bad), 64'd0);
        check_val({tag, "_rsp_early"}, 64'(rsp_valid), 64'd0);
        step();
        check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_ready_at_rsp"}, 64'(req_ready), 64'd1);
        check_val({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        check_val({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    endtask

    task automatic post_rsp(input string tag, input logic [15:0] exp_rd, input logic exp_err);
        step();
        check_val({tag, "_rsp_pulse_end"}, 64'(rsp_valid), 64'd0);
        check_val({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(exp_rd));
        check_val({tag, "_err_hold"}, 64'(rsp_err), 64'(exp_err));
        check_idle_bus({tag, "_idle"});
    endtask

    initial begin
        int rsp_seen;
        rst_int_n    = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_phy_addr = '0;
        req_reg_addr = '0;
        req_wdata    = '0;
        phy_mdio_i   = 1'b1;
        repeat (3) step();

        check_idle_bus("reset");
        check_val("reset_ready", 64'(req_ready), 64'd1);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("reset_rdata", 64'(rsp_rdata), 64'd0);
        check_val("reset_err", 64'(rsp_err), 64'd0);
        rst_int_n = 1'b1;
        repeat (2) step();

        // Write phy 1 reg 0 = 0x1140: 01 01 00001 00000 10 -> 0x5082.
        run_frame("wr1140", 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 32'h5082_1140, 18'h3FFFF, 16'h0000, 1'b0);
        post_rsp("wr1140", 16'h0000, 1'b0);

        // Read phy 1 reg 2: 01 10 00001 00010 11 -> 0x608B; PHY answers TA 10, 0x0141.
        run_frame("rd0141", 1'b0, 5'd1, 5'd2, 16'h0000, 1'b0, 32'h608B_FFFF, {2'b10, 16'h0141}, 16'h0141, 1'b0);
        post_rsp("rd0141", 16'h0141, 1'b0);

        // Read phy 0 reg 16: 01 10 00000 10000 11 -> 0x6043; TA 00, data 0x8001.
        run_frame("rd8001", 1'b0, 5'd0, 5'd16, 16'h0000, 1'b0, 32'h6043_FFFF, {2'b00, 16'h8001}, 16'h8001, 1'b0);
        post_rsp("rd8001", 16'h8001, 1'b0);

        // Read phy 31 reg 31 with nothing answering: 0x6FFF, missing turnaround.
        run_frame("rd_noresp", 1'b0, 5'd31, 5'd31, 16'h0000, 1'b0, 32'h6FFF_FFFF, 18'h3FFFF, 16'hFFFF, 1'b1);
        post_rsp("rd_noresp", 16'hFFFF, 1'b1);

        // Reset during bit 20 of a write.
        req_write    = 1'b1;
        req_phy_addr = 5'd5;
        req_reg_addr = 5'd9;
        req_wdata    = 16'h5555;
        req_valid    = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (20 * 2 * CLK_DIV + 2) step();
        check_val("midframe_busy", 64'(busy), 64'd1);
        rst_int_n = 1'b0;
        req_valid = 1'b1;
        step();
        check_idle_bus("abort");
        check_val("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("abort_rdata", 64'(rsp_rdata), 64'd0);
        check_val("abort_err", 64'(rsp_err), 64'd0);
        step();
        check_val("abort_ready_in_reset", 64'(req_ready), 64'd1);
        rst_int_n = 1'b1;
        req_valid = 1'b0;
        step();
        check_val("abort_ready_after", 64'(req_ready), 64'd1);
        rsp_seen = 0;
        for (int c = 0; c < FRAME_CYC + 8; c++) begin
            if (rsp_valid === 1'b1) rsp_seen++;
            step();
        end
        check_val("abort_no_rsp", 64'(rsp_seen), 64'd0);
        check_idle_bus("abort_idle");

        // Back-to-back writes with req_valid held: 0x5192 then 0x5936.
        run_frame("b2b_1", 1'b1, 5'd3, 5'd4, 16'h0000, 1'b1, 32'h5192_0000, 18'h3FFFF, 16'h0000, 1'b0);
        run_frame("b2b_2", 1'b1, 5'd18, 5'd13, 16'hA5C3, 1'b0, 32'h5936_A5C3, 18'h3FFFF, 16'h0000, 1'b0);
        post_rsp("b2b_2", 16'h0000, 1'b0);
        check_val("final_ready", 64'(req_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
